voltage_frame_uart_tx: RTL and testbench
========================================

// Module: voltage_frame_uart_tx
// PURPOSE
//  Downstream consumer of the circuit-simulator core's node-voltage outputs.
//  Captures one sample (integer/decimal parts of node-2 voltage plus logic output a) per
//  sample_valid strobe, packs it into a fixed 7-byte frame and transmits it 8N1 on a UART
//  line to the host PC for logging and plotting. Single-entry capture; samples arriving
//  mid-frame are dropped and counted.
// PARAMETERS
//  CLK_HZ    12_000_000  board clock frequency, Hz
//  BAUD      115200      UART bit rate
//  BAUD_DIV  CLK_HZ/BAUD clocks per UART bit (integer, truncated; 104 at defaults; must be >=2)
//  HDR_BYTE  8'hA5       frame sync byte
// PORTS
//  Clk          in   1   system clock; all logic on rising edge
//  Rst          in   1   synchronous, active-high reset
//  sample_valid in   1   one-cycle strobe: v_int/v_dec/a valid this cycle
//  v_int        in   16  node-2 voltage, integer part (unsigned)
//  v_dec        in   16  node-2 voltage, decimal part (unsigned)
//  a            in   1   simulated gate logic output
//  tx           out  1   UART serial line, idle high
//  busy         out  1   frame in progress; new samples dropped while 1
//  drop_cnt     out  8   samples dropped while busy, saturating
// BEHAVIOUR
//  Reset (Rst=1 at a rising edge): next cycle tx=1, busy=0, drop_cnt=0, FSM=IDLE, bit/byte
//   counters 0. Reset mid-frame aborts immediately (tx goes high, no completion of byte).
//  Accept: at edge k with sample_valid=1 and busy=0 (registered value), capture v_int, v_dec, a;
//   from edge k+1 busy=1 and tx=0 (start bit of byte 0). Latency strobe->start bit = 1 cycle.
//  Frame bytes, in order: B0=HDR_BYTE, B1=v_int[15:8], B2=v_int[7:0], B3=v_dec[15:8],
//   B4=v_dec[7:0], B5={7'b0,a}, B6=B1^B2^B3^B4^B5 (XOR checksum, header excluded).
//  Byte serialisation: start bit 0, data LSB first (8 bits), stop bit 1; each bit held exactly
//   BAUD_DIV cycles. Bytes back-to-back, no idle gap. Frame = 70*BAUD_DIV cycles.
//  busy falls at edge k+1+70*BAUD_DIV (end of B6 stop bit); tx stays 1 while idle.
//  Same-cycle hand-off: sample_valid in the cycle busy is first 0 is accepted (zero-gap frames).
//  Drop: sample_valid=1 while busy=1 -> sample ignored, drop_cnt+1, saturating at 8'hFF.
//   Captured data never changes mid-frame.
//  FSM states: IDLE (tx=1; wait accept) -> START (tx=0, BAUD_DIV cycles) -> DATA (8 bits,
//   bit_idx 0..7) -> STOP (tx=1, BAUD_DIV cycles) -> START if byte_idx<6 (byte_idx+1),
//   else IDLE (byte_idx=0, busy=0).
//  Counters: baud_cnt counts 0..BAUD_DIV-1 and wraps; bit_idx 3 bits; byte_idx 3 bits (0..6).
//  tx is driven from a register (glitch-free).
// STRUCTURE
//  Shared package sim_io_pkg: HDR_BYTE, FRAME_LEN=7, FSM state encoding localparams,
//   checksum function (xor of 5 bytes) reused by the host-side bench model.
//  One sub-module: uart_tx_byte (Clk, Rst, start, data[7:0] -> tx, done; holds one 8N1 byte,
//   BAUD_DIV param). Top level holds capture regs, byte mux, byte_idx, drop counter.
// TESTING  (sim params CLK_HZ=16, BAUD=4 -> BAUD_DIV=4; frame = 280 cycles)
//  1 Reset: hold Rst 3 cycles mid-frame -> next cycle tx=1, busy=0, drop_cnt=0; no further edges.
//  2 Single frame: v_int=16'h0003, v_dec=16'h1F40, a=1 -> bytes A5 00 03 1F 40 01 5D decoded
//    by bench UART model; tx=0 one cycle after strobe; busy low exactly 281 cycles after strobe.
//  3 Drop: strobe at cycle 0 then 3 strobes during frame -> drop_cnt=3; frame carries cycle-0 data.
//  4 Back-to-back: second strobe in first cycle busy=0 -> accepted, no idle bit between frames;
//    300 strobes while busy -> drop_cnt saturates at 8'hFF.
//  5 Bit timing: every tx level held exactly 4 cycles; byte LSB-first; stop bit=1 for each byte.
//  6 Zero frame: v_int=0, v_dec=0, a=0 -> A5 00 00 00 00 00 00.

Source files
------------

// File: rtl/sim_io_pkg.sv
// Shared definitions for the node-voltage logging link.
//   HDR_BYTE       : frame sync byte that leads every frame
//   FRAME_LEN      : bytes per frame (header, 5 payload bytes, checksum)
//   LAST_BYTE_IDX  : index of the checksum byte within a frame
//   tx_state_e     : serialiser FSM encoding
//   frame_checksum : XOR of the five payload bytes (header excluded); the
//                    host-side decoder uses the same function
package sim_io_pkg;

  localparam logic [7:0] HDR_BYTE      = 8'hA5;
  localparam int         FRAME_LEN     = 7;
  localparam logic [2:0] LAST_BYTE_IDX = 3'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [7:0] frame_checksum(
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3,
    input logic [7:0] b4,
    input logic [7:0] b5
  );
    return b1 ^ b2 ^ b3 ^ b4 ^ b5;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte 8N1 UART serialiser.
//   Clk   in  : system clock, rising edge
//   Rst   in  : synchronous active-high reset; aborts any byte, line returns high
//   start in  : load `data` and begin a byte; honoured in IDLE and in the last
//               cycle of a stop bit (so consecutive bytes have no gap)
//   data  in  : byte to send, sampled only when start is accepted
//   tx    out : serial line, registered, idle high
//   done  out : high during the final cycle of the stop bit
// Every bit (start, 8 data LSB first, stop) is held exactly BAUD_DIV cycles.
module uart_tx_byte #(
  parameter int BAUD_DIV = 104
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);
  import sim_io_pkg::*;

  localparam int                CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             tx_q;
  logic             bit_end;

  assign bit_end = (baud_cnt_q == BAUD_LAST);
  assign done    = (state_q == ST_STOP) && bit_end;
  assign tx      = tx_q;

  // The shift register is pure data and carries no reset; the line level and
  // all sequencing state are reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q       <= 1'b1;
          baud_cnt_q <= '0;
          bit_idx_q  <= 3'd0;
          if (start) begin
            state_q <= ST_START;
            shreg_q <= data;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            tx_q       <= shreg_q[0];
            state_q    <= ST_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              // Shift right so the next data bit is always in position 1.
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shreg_q[1];
              shreg_q   <= {1'b0, shreg_q[7:1]};
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            if (start) begin
              // Chain straight into the next start bit without an idle cycle.
              state_q <= ST_START;
              shreg_q <= data;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/voltage_frame_uart_tx.sv
// Captures one node-voltage sample per sample_valid strobe and streams it to
// the host as a 7-byte 8N1 frame:
//   A5, v_int[15:8], v_int[7:0], v_dec[15:8], v_dec[7:0], {7'b0,a}, XOR checksum
// Ports:
//   Clk          in  : system clock, rising edge
//   Rst          in  : synchronous active-high reset; aborts a frame in flight
//   sample_valid in  : one-cycle strobe qualifying v_int/v_dec/a
//   v_int        in  : node-2 voltage, integer part
//   v_dec        in  : node-2 voltage, decimal part
//   a            in  : gate logic output
//   tx           out : UART line, idle high
//   busy         out : frame in progress; strobes seen while high are dropped
//   drop_cnt     out : dropped-sample count, saturates at 8'hFF
module voltage_frame_uart_tx #(
  parameter int         CLK_HZ   = 12_000_000,
  parameter int         BAUD     = 115200,
  parameter int         BAUD_DIV = CLK_HZ / BAUD,
  parameter logic [7:0] HDR_BYTE = sim_io_pkg::HDR_BYTE
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        sample_valid,
  input  logic [15:0] v_int,
  input  logic [15:0] v_dec,
  input  logic        a,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  import sim_io_pkg::*;

  logic [15:0] v_int_q;
  logic [15:0] v_dec_q;
  logic        a_q;

  logic        busy_q,     busy_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic        accept;
  logic        drop_hit;
  logic        last_byte;
  logic [2:0]  next_idx;
  logic        byte_start;
  logic        byte_done;
  logic [7:0]  byte_data;

  function automatic logic [7:0] frame_byte(
    input logic [2:0]  idx,
    input logic [15:0] vi,
    input logic [15:0] vd,
    input logic        av
  );
    logic [7:0] b5;
    b5 = {7'b0, av};
    case (idx)
      3'd0:    return HDR_BYTE;
      3'd1:    return vi[15:8];
      3'd2:    return vi[7:0];
      3'd3:    return vd[15:8];
      3'd4:    return vd[7:0];
      3'd5:    return b5;
      3'd6:    return frame_checksum(vi[15:8], vi[7:0], vd[15:8], vd[7:0], b5);
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    accept     = sample_valid & ~busy_q;
    drop_hit   = sample_valid & busy_q;
    last_byte  = (byte_idx_q == LAST_BYTE_IDX);
    next_idx   = byte_idx_q + 3'd1;
    // A new frame starts with the header; otherwise the next byte is queued
    // into the serialiser on the last stop-bit cycle of the current one.
    byte_start = accept | (busy_q & byte_done & ~last_byte);
    byte_data  = accept ? HDR_BYTE : frame_byte(next_idx, v_int_q, v_dec_q, a_q);

    busy_d     = busy_q;
    byte_idx_d = byte_idx_q;
    drop_cnt_d = drop_cnt_q;

    if (accept) begin
      busy_d     = 1'b1;
      byte_idx_d = 3'd0;
    end else if (busy_q && byte_done) begin
      if (last_byte) begin
        busy_d     = 1'b0;
        byte_idx_d = 3'd0;
      end else begin
        byte_idx_d = next_idx;
      end
    end

    if (drop_hit && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      busy_q     <= 1'b0;
      byte_idx_q <= 3'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      busy_q     <= busy_d;
      byte_idx_q <= byte_idx_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Sample capture: written only on accept, so the payload is frozen for the
  // whole frame.
  always_ff @(posedge Clk) begin
    if (accept) begin
      v_int_q <= v_int;
      v_dec_q <= v_dec;
      a_q     <= a;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (byte_start),
    .data  (byte_data),
    .tx    (tx),
    .done  (byte_done)
  );

  assign busy     = busy_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_voltage_frame_uart_tx.sv
module tb_voltage_frame_uart_tx;
  import sim_io_pkg::*;

  localparam int CLK_HZ    = 16;
  localparam int BAUD      = 4;
  localparam int BD        = CLK_HZ / BAUD;
  localparam int FRAME_CYC = 70 * BD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sv  = 1'b0;
  logic [15:0] vi  = 16'h0;
  logic [15:0] vd  = 16'h0;
  logic        av  = 1'b0;
  logic        tx;
  logic        busy;
  logic [7:0]  drop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  voltage_frame_uart_tx #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .HDR_BYTE (8'hA5)
  ) dut (
    .Clk          (clk),
    .Rst          (rst),
    .sample_valid (sv),
    .v_int        (vi),
    .v_dec        (vd),
    .a            (av),
    .tx           (tx),
    .busy         (busy),
    .drop_cnt     (drop)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is a precomputed line waveform of 70 bits x BD
  // cycles; the model just plays it back after an accepted strobe.
  bit         m_ok = 1'b0;
  bit         m_busy = 1'b0;
  int         m_pos = 0;
  bit         m_level [FRAME_CYC];
  logic       m_tx = 1'b1;
  logic [7:0] m_drop = 8'h0;

  task automatic build_frame(input logic [15:0] i, input logic [15:0] d, input logic a_in);
    logic [7:0] by [7];
    logic       lvl;
    by[0] = 8'hA5;
    by[1] = i[15:8];
    by[2] = i[7:0];
    by[3] = d[15:8];
    by[4] = d[7:0];
    by[5] = {7'b0, a_in};
    by[6] = frame_checksum(by[1], by[2], by[3], by[4], by[5]);
    for (int b = 0; b < 7; b++)
      for (int k = 0; k < 10; k++) begin
        if (k == 0)      lvl = 1'b0;
        else if (k == 9) lvl = 1'b1;
        else             lvl = by[b][k-1];
        for (int c = 0; c < BD; c++) m_level[(b*10 + k)*BD + c] = lvl;
      end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_busy = 1'b0; m_pos = 0; m_tx = 1'b1; m_drop = 8'h0;
    end else if (m_ok) begin
      if (sv && m_busy && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      if (m_busy) begin
        m_pos++;
        if (m_pos == FRAME_CYC) begin
          m_busy = 1'b0;
          m_tx   = 1'b1;
        end else begin
          m_tx = m_level[m_pos];
        end
      end else if (sv) begin
        build_frame(vi, vd, av);
        m_pos  = 0;
        m_busy = 1'b1;
        m_tx   = m_level[0];
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_tx", {31'b0, tx}, {31'b0, m_tx});
      chk("model_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("model_drop", {24'b0, drop}, {24'b0, m_drop});
    end
  end

  // Host-side UART receiver: mid-bit sampling, collects bytes into rx_q.
  int         d_t = -1;
  logic [7:0] d_sh;
  logic [7:0] rx_q [$];

  always @(negedge clk) begin
    if (rst) begin
      d_t = -1;
    end else if (d_t < 0) begin
      if (tx === 1'b0) d_t = 0;
    end else begin
      d_t++;
      if (d_t == 9*BD + BD/2) begin
        chk("stop_bit", {31'b0, tx}, 32'd1);
        rx_q.push_back(d_sh);
        d_t = -1;
      end else if (d_t >= BD + BD/2 && (d_t % BD) == BD/2) begin
        d_sh = {tx, d_sh[7:1]};
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [15:0] i, input logic [15:0] d, input logic a_in);
    vi = i; vd = d; av = a_in; sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int n);
    n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("wait_idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_rx(input string nm, input logic [7:0] e0, e1, e2, e3, e4, e5, e6,
                          input int reps);
    logic [7:0] e [7];
    e = '{e0, e1, e2, e3, e4, e5, e6};
    chk({nm, "_count"}, rx_q.size(), 7*reps);
    for (int i = 0; i < rx_q.size() && i < 7*reps; i++)
      chk({nm, "_byte"}, {24'b0, rx_q[i]}, {24'b0, e[i % 7]});
    rx_q.delete();
  endtask

  int n;
  int zc;
  int lows;

  initial begin
    // Reset state
    rst = 1'b1;
    tick(3);
    chk("reset_tx", {31'b0, tx}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_drop", {24'b0, drop}, 32'd0);
    rst = 1'b0;
    tick(2);

    chk("checksum_fn", {24'b0, frame_checksum(8'h00, 8'h03, 8'h1F, 8'h40, 8'h01)}, 32'h5D);

    // Single frame, latency and length
    rx_q.delete();
    strobe(16'h0003, 16'h1F40, 1'b1);
    chk("start_latency_tx", {31'b0, tx}, 32'd0);
    chk("start_latency_busy", {31'b0, busy}, 32'd1);
    wait_idle(400, n);
    chk("busy_low_cycles", n + 1, 281);
    tick(2);
    check_rx("frame1", 8'hA5, 8'h00, 8'h03, 8'h1F, 8'h40, 8'h01, 8'h5D, 1);

    // Reset mid-frame, with a drop recorded first
    strobe(16'h5555, 16'hAAAA, 1'b1);
    tick(10);
    strobe(16'h1111, 16'h2222, 1'b0);
    tick(40);
    chk("pre_reset_drop", {24'b0, drop}, 32'd1);
    rst = 1'b1;
    tick(1);
    chk("midreset_tx", {31'b0, tx}, 32'd1);
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_drop", {24'b0, drop}, 32'd0);
    tick(2);
    rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("post_reset_no_edges", lows, 0);
    rx_q.delete();

    // Drops during a frame; payload stays from the accepted strobe
    strobe(16'h1234, 16'hABCD, 1'b0);
    tick(9);
    strobe(16'hFFFF, 16'hFFFF, 1'b1);
    tick(90);
    strobe(16'h0F0F, 16'hF0F0, 1'b1);
    tick(90);
    strobe(16'h7777, 16'h8888, 1'b0);
    wait_idle(400, n);
    chk("drop_count3", {24'b0, drop}, 32'd3);
    tick(2);
    check_rx("frame_drop", 8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h40, 1);

    // Back-to-back frames with sample_valid held high; drop counter saturates
    vi = 16'hBEEF; vd = 16'h0102; av = 1'b1; sv = 1'b1;
    zc = 0;
    for (int c = 1; c < 600; c++) begin
      @(negedge clk);
      if (busy === 1'b0) zc++;
    end
    sv = 1'b0;
    chk("handoff_idle_cycles", zc, 2);
    wait_idle(400, n);
    chk("drop_saturated", {24'b0, drop}, 32'hFF);
    tick(2);
    check_rx("b2b", 8'hA5, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h01, 8'h53, 3);

    // Zero frame after a fresh reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("zero_pre_drop", {24'b0, drop}, 32'd0);
    strobe(16'h0000, 16'h0000, 1'b0);
    wait_idle(400, n);
    tick(2);
    check_rx("frame_zero", 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);

    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
